// File: rtl/fib_engine_pkg.sv
// Shared types and default widths for the Fibonacci engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fib_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fib_state_t;

    localparam int FIB_WIDTH_DEF = 16;
    localparam int FIB_NW_DEF    = 16;

endpackage

// File: rtl/fib_engine_if.sv
// Request/response bundle between a requester and fib_engine.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the engine is idle.
//
// Signals: start/n (request), busy/done/result/ovf (response),
//          term_valid/term (per-term stream, zero when the stream build is off).
// Modports: master = requester side, slave = engine side.
interface fib_engine_if
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH_DEF,
    parameter int NW    = FIB_NW_DEF
);
    logic             start;
    logic [NW-1:0]    n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             term_valid;
    logic [WIDTH-1:0] term;

    modport master (
        output start, n,
        input  busy, done, result, ovf, term_valid, term
    );

    modport slave (
        input  start, n,
        output busy, done, result, ovf, term_valid, term
    );
endinterface

// File: rtl/fib_engine_step.sv
// One Fibonacci iteration: (a, b) -> (b, a+b) with wrap and carry tracking.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: a, b, b_ovf in; next_a, next_b, next_b_ovf, next_a_ovf out.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_ovf,
    output logic [WIDTH-1:0] next_a,
    output logic [WIDTH-1:0] next_b,
    output logic             next_b_ovf,
    output logic             next_a_ovf
);
    logic carry;

    assign {carry, next_b} = {1'b0, a} + {1'b0, b};
    assign next_a          = b;
    // Once any term has wrapped, every later term is also too large, so the
    // flag is sticky and travels with the value as it shifts into a.
    assign next_b_ovf      = b_ovf | carry;
    assign next_a_ovf      = b_ovf;
endmodule

// File: rtl/fib_engine.sv
// Sequential Fibonacci generator: F(n) mod 2^WIDTH plus sticky overflow flag.
// Latency: done n+1 cycles after the edge that accepts start.
// Backpressure: none; start is ignored while busy, no queueing.
//
// Ports: clk, reset (synchronous, active-high), bus (fib_engine_if.slave).
// Optional build macro FIB_STREAM_EN: strobes term_valid/term with F(k) on
// every RUN cycle; when undefined term_valid and term are held at zero.
module fib_engine
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH_DEF,
    parameter int NW    = FIB_NW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fib_engine_if.slave   bus
);
    localparam logic [NW-1:0]    K_ONE  = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] B_INIT = {{(WIDTH-1){1'b0}}, 1'b1};

    fib_state_t       state;
    logic [NW-1:0]    n_lat;
    logic [NW-1:0]    k;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_ovf;
    logic             b_ovf;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             ovf_r;

    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic             next_a_ovf;
    logic             next_b_ovf;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a          (a),
        .b          (b),
        .b_ovf      (b_ovf),
        .next_a     (next_a),
        .next_b     (next_b),
        .next_b_ovf (next_b_ovf),
        .next_a_ovf (next_a_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            n_lat    <= '0;
            k        <= '0;
            a        <= '0;
            b        <= '0;
            a_ovf    <= 1'b0;
            b_ovf    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_lat    <= bus.n;
                        k        <= '0;
                        a        <= '0;
                        b        <= B_INIT;
                        a_ovf    <= 1'b0;
                        b_ovf    <= 1'b0;
                        result_r <= '0;
                        ovf_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Compare before incrementing so n = 2^NW-1 matches
                    // without k ever wrapping.
                    if (k == n_lat) begin
                        result_r <= a;
                        ovf_r    <= a_ovf;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        a     <= next_a;
                        b     <= next_b;
                        a_ovf <= next_a_ovf;
                        b_ovf <= next_b_ovf;
                        k     <= k + K_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.ovf    = ovf_r;

`ifdef FIB_STREAM_EN
    logic             term_valid_r;
    logic [WIDTH-1:0] term_r;

    // a holds F(k) during each RUN cycle, including the final one, so this
    // yields n+1 strobes and the last lines up with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            term_valid_r <= 1'b0;
            term_r       <= '0;
        end else begin
            term_valid_r <= 1'b0;
            if (state == RUN) begin
                term_valid_r <= 1'b1;
                term_r       <= a;
            end
        end
    end

    assign bus.term_valid = term_valid_r;
    assign bus.term       = term_r;
`else
    assign bus.term_valid = 1'b0;
    assign bus.term       = '0;
`endif
endmodule

// File: tb/tb_fib_engine.sv
// Scoreboard bench for fib_engine: driver pushes expectations, monitor pops on done.
// Latency: checks done arrives exactly n+1 cycles after the accepting edge.
// Backpressure: n/a.
module tb_fib_engine;
    import fib_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    fib_engine_if #(.WIDTH(16), .NW(16)) bus ();

    fib_engine #(.WIDTH(16), .NW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          n;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] term_q[$];
    int          checks = 0;
    int          passes = 0;
    int          busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic issue(input int nn, input logic [15:0] r, input logic o);
        exp_t        e;
        logic [15:0] x, y, t;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.n      = nn[15:0];
        e.res      = r;
        e.ovf      = o;
        e.n        = nn;
        e.done_cyc = cyc + nn + 2;
        exp_q.push_back(e);
        x = 16'd0;
        y = 16'd1;
        for (int i = 0; i <= nn; i++) begin
            term_q.push_back(x);
            t = x + y;
            x = y;
            y = t;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (i == budget) begin
            fail_now("done_timeout");
            exp_q.delete();
            term_q.delete();
        end
    endtask

    // Monitor: compares every completion and stream strobe against the queues.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
`ifdef FIB_STREAM_EN
            if (bus.term_valid) begin
                if (term_q.size() == 0) fail_now("unexpected_term_valid");
                else chk("term", {16'd0, bus.term}, {16'd0, term_q.pop_front()});
            end
`endif
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result",        {16'd0, bus.result}, {16'd0, e.res});
                    chk("ovf",           {31'd0, bus.ovf},    {31'd0, e.ovf});
                    chk("done_cycle",    cyc,                 e.done_cyc);
                    chk("busy_cycles",   busy_cnt,            e.n + 1);
                    chk("busy_at_done",  {31'd0, bus.busy},   32'd0);
`ifdef FIB_STREAM_EN
                    chk("last_strobe_at_done", {31'd0, bus.term_valid}, 32'd1);
                    chk("terms_left",    term_q.size(),       32'd0);
`else
                    chk("term_valid_off", {31'd0, bus.term_valid}, 32'd0);
                    chk("term_off",      {16'd0, bus.term},   32'd0);
`endif
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.n     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",       {31'd0, bus.busy},       32'd0);
        chk("rst_done",       {31'd0, bus.done},       32'd0);
        chk("rst_result",     {16'd0, bus.result},     32'd0);
        chk("rst_ovf",        {31'd0, bus.ovf},        32'd0);
        chk("rst_term_valid", {31'd0, bus.term_valid}, 32'd0);
        chk("rst_term",       {16'd0, bus.term},       32'd0);

        issue(0,  16'd0,     1'b0); wait_idle(50);
        issue(10, 16'd55,    1'b0); wait_idle(50);
        issue(24, 16'd46368, 1'b0); wait_idle(50);
        issue(25, 16'd9489,  1'b1); wait_idle(50);
        issue(1,  16'd1,     1'b0); wait_idle(50);
        issue(2,  16'd1,     1'b0); wait_idle(50);
        issue(23, 16'd28657, 1'b0); wait_idle(50);
        issue(5,  16'd5,     1'b0); wait_idle(50);

        // start pulsed mid-run must be ignored; any second done is flagged.
        issue(20, 16'd6765, 1'b0);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.n     = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(60);
        repeat (30) @(negedge clk);
        chk("ignored_start_result", {16'd0, bus.result}, 32'd6765);

        // Reset mid-run: everything clears, no done ever appears.
        issue(30, 16'd0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        term_q.delete();
        @(negedge clk);
        chk("midrst_busy",   {31'd0, bus.busy},   32'd0);
        chk("midrst_done",   {31'd0, bus.done},   32'd0);
        chk("midrst_result", {16'd0, bus.result}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("after_rst_result", {16'd0, bus.result}, 32'd0);
        chk("after_rst_busy",   {31'd0, bus.busy},   32'd0);
        issue(1, 16'd1, 1'b0); wait_idle(50);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
